line_window_buffer: RTL and testbench
=====================================

# line_window_buffer

- Parametrised line buffer for the edge-detector datapath, placed between the pixel source and the Sobel/convolution stage.
- Stores the previous `ROWS-1` image lines in block-RAM-inferable storage and emits, per accepted pixel, one vertical column of `ROWS` pixels at the same x position.
- Adds what the fixed 76-entry shift store lacks:
  - configurable data width, line length and row count;
  - valid/ready flow control on both sides;
  - start-of-frame resynchronisation;
  - a window-valid flag that masks stale lines after reset or a new frame.

## Interface
Parameters:
- `DATA_W`, 32, pixel width in bits
- `LINE_W`, 76, pixels per line (≥2)
- `ROWS`, 3, column height, i.e. stored lines + 1 (≥2)
- `Y_W`, 16, row counter width

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  input pixel present
- `in_ready`  out  1  block can accept a pixel this cycle
- `in_data`  in  `DATA_W`  pixel value
- `in_sof`  in  1  qualifies `in_data` as pixel (0,0) of a new frame
- `out_valid`  out  1  output column present
- `out_ready`  in  1  downstream accepts the column
- `out_col`  out  `ROWS*DATA_W`  column; slice 0 (LSBs) = current pixel, slice `ROWS-1` (MSBs) = oldest line
- `out_x`  out  `$clog2(LINE_W)`  x of the column
- `out_y`  out  `Y_W`  y of the column, saturating
- `out_win_ok`  out  1  all `ROWS` slices belong to the current frame (y ≥ `ROWS-1`)

## Operation
Acceptance:
- A pixel is accepted when `in_valid && in_ready`.
- `in_ready = !out_valid || out_ready`: single output register with pass-through backpressure. There is no other buffering.

Per accepted pixel at (x, y):
- Read line k at address x, for k = 1..`ROWS-1`, giving pixel (x, y-k).
- Write `in_data` into line 1 at x. Write old line k into line k+1 at x. This is a read-before-write cascade, the same cycle.
- Load `out_col` = {line`ROWS-1`..line1, `in_data`}, plus `out_x` = x and `out_y` = y.
- Set `out_win_ok` = (y ≥ `ROWS-1`).

Counters:
- x increments per accepted pixel and wraps `LINE_W-1` → 0.
- y increments on that wrap and saturates at 2^`Y_W`-1.
- Accepting a pixel with `in_sof`=1 forces that pixel's coordinates to (0,0); the next pixel is (1,0).
- An `in_sof` mid-line restarts counters the same way, and the partially written line stays as stale data masked by `out_win_ok`.
- `in_sof` with `in_valid`=0 is ignored.

Output handshake:
- `out_valid` sets on acceptance and clears on `out_ready` without a new acceptance.
- Simultaneous consume and accept keeps `out_valid`=1 and loads the new column.
- Output fields hold stable while `out_valid && !out_ready`.

Reset (`rst_n` low, any time, including mid-line):
- x, y, `out_valid`, `out_col`, `out_x`, `out_y` and `out_win_ok` go to 0.
- `in_ready` reads 1 during reset.
- RAM contents are not cleared; `out_win_ok` masks them until `ROWS-1` full lines have been written.

## Timing
- Latency 1 cycle: a pixel accepted at edge n appears on the outputs after edge n, with `out_valid`=1.
- Throughput 1 pixel/clk while `out_ready`=1.
- RAM read is synchronous. Address is the current x, and the write-then-read hazard cannot occur because each address is touched once per line.
- With `ROWS`=3, `LINE_W`=76, the first `out_win_ok`=1 is the 153rd accepted pixel, (0,2).
- `in_ready` is combinational from `out_ready` and `out_valid`. There is no combinational path from `in_valid` to any output.

## Structure
- Package `edge_pkg`: default `LINE_W` (76), default `DATA_W`, and a `clog2`-based address width helper shared with the other edge-detector blocks.
- Sub-module `line_ram`: one `LINE_W`×`DATA_W` single-port RAM with registered read-before-write. It carries no reset, so that it infers block RAM.
- `line_window_buffer` instantiates `ROWS-1` copies of `line_ram` via generate, plus the counters and the output register.

## Test plan
Unless noted, benches use `DATA_W`=8, `LINE_W`=4, `ROWS`=3.

- **Fill:** stream pixels 0..11 with `in_sof` on pixel 0, `out_ready`=1.
  - Pixel 8 → `out_col`={0x00,0x04,0x08}, (0,2), `out_win_ok`=1.
  - Pixels 0..7 → `out_win_ok`=0.
- **Backpressure:** hold `out_ready`=0 after pixel 5.
  - `in_ready`=0 next cycle, and outputs stay {.., 0x05}, (1,1) for 10 cycles.
  - Release → pixel 6 accepted, no loss or duplication.
- **Wrap:** 3 lines → `out_x` sequence 0,1,2,3,0,1,2,3,0…; `out_y` increments only on the 3→0 wrap.
- **Mid-line resync:** `in_sof` on the 3rd pixel of line 2 → that pixel reports (0,0), `out_win_ok`=0 until (0,2) of the new frame.
- **Async reset:** assert `rst_n`=0 mid-line between clock edges.
  - Outputs go to zero immediately.
  - After release, the first pixel reports (0,0).
- **Parametric:** `DATA_W`=32, `LINE_W`=76, `ROWS`=5 → first `out_win_ok`=1 at pixel 304 with column {p0,p76,p152,p228,p304}.

Source files
------------

// File: rtl/edge_pkg.sv
// Shared definitions for the edge-detector datapath blocks:
// default image geometry and the address-width helper.
package edge_pkg;

    localparam int EDGE_LINE_W = 76;
    localparam int EDGE_DATA_W = 32;

    // Address width for a memory of 'depth' entries, never less than one bit.
    function automatic int addr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/line_window_buffer_if.sv
// Pixel-in / column-out handshake bundle of the line window buffer.
// 'master' is the side that feeds pixels and consumes columns,
// 'slave' is the buffer itself.
interface line_window_buffer_if #(
    parameter int DATA_W = edge_pkg::EDGE_DATA_W,
    parameter int LINE_W = edge_pkg::EDGE_LINE_W,
    parameter int ROWS   = 3,
    parameter int Y_W    = 16
);
    import edge_pkg::*;

    localparam int X_W = addr_w(LINE_W);

    logic                   in_valid;
    logic                   in_ready;
    logic [DATA_W-1:0]      in_data;
    logic                   in_sof;
    logic                   out_valid;
    logic                   out_ready;
    logic [ROWS*DATA_W-1:0] out_col;
    logic [X_W-1:0]         out_x;
    logic [Y_W-1:0]         out_y;
    logic                   out_win_ok;

    modport master (
        output in_valid, in_data, in_sof, out_ready,
        input  in_ready, out_valid, out_col, out_x, out_y, out_win_ok
    );

    modport slave (
        input  in_valid, in_data, in_sof, out_ready,
        output in_ready, out_valid, out_col, out_x, out_y, out_win_ok
    );

endinterface

// File: rtl/line_window_buffer_line_ram.sv
// One image line of storage: single-port RAM with a registered,
// read-before-write port. No reset so it maps onto block RAM.
module line_ram
    import edge_pkg::*;
#(
    parameter int DATA_W = EDGE_DATA_W,
    parameter int DEPTH  = EDGE_LINE_W,
    parameter int A_W    = addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [A_W-1:0]    addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Old contents are returned while the new word is written to the same address.
    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem[addr];
            if (we) begin
                mem[addr] <= wdata;
            end
        end
    end

endmodule

// File: rtl/line_window_buffer.sv
// Line window buffer: keeps the last ROWS-1 image lines and emits, per
// accepted pixel, the vertical column of ROWS pixels at the same x.
// Lines live in a ring of ROWS-1 RAMs; only the RAM holding the oldest
// line is written each pixel (its old word is the oldest slice), so no
// data is copied between RAMs and the column is reassembled by rotation.
module line_window_buffer
    import edge_pkg::*;
#(
    parameter int DATA_W = EDGE_DATA_W,
    parameter int LINE_W = EDGE_LINE_W,
    parameter int ROWS   = 3,
    parameter int Y_W    = 16
) (
    input logic                clk,
    input logic                rst_n,
    line_window_buffer_if.slave bus
);

    localparam int X_W  = addr_w(LINE_W);
    localparam int NRAM = ROWS - 1;
    localparam int S_W  = addr_w(NRAM);

    // Stage 0: coordinates of the pixel being offered, after sof override.
    logic              accept;
    logic [X_W-1:0]    x_cnt, x_p0;
    logic [Y_W-1:0]    y_cnt, y_p0;
    logic [S_W-1:0]    sel_cnt, sel_p0;

    // Stage 1: output register.
    logic              vld_p1;
    logic              primed_p1;
    logic [DATA_W-1:0] pix_p1;
    logic [X_W-1:0]    x_p1;
    logic [Y_W-1:0]    y_p1;
    logic              win_p1;
    logic [S_W-1:0]    sel_p1;

    logic [DATA_W-1:0]      rd_data [NRAM];
    logic [ROWS*DATA_W-1:0] col;

    function automatic logic [Y_W-1:0] sat_inc_y(input logic [Y_W-1:0] y);
        return (&y) ? y : y + Y_W'(1);
    endfunction

    function automatic logic [S_W-1:0] ring_inc(input logic [S_W-1:0] s);
        return (s == S_W'(NRAM - 1)) ? '0 : s + S_W'(1);
    endfunction

    // RAM index holding the line written k lines before the one selected by s.
    function automatic int ring_idx(input logic [S_W-1:0] s, input int k);
        int t;
        t = int'(s) - k;
        if (t < 0) begin
            t = t + NRAM;
        end
        return t;
    endfunction

    // Handshake and the coordinates this pixel will carry.
    always_comb begin
        bus.in_ready = !vld_p1 || bus.out_ready;
        accept       = bus.in_valid && bus.in_ready;
        x_p0         = bus.in_sof ? '0 : x_cnt;
        y_p0         = bus.in_sof ? '0 : y_cnt;
        sel_p0       = bus.in_sof ? '0 : sel_cnt;
    end

    genvar g;
    generate
        for (g = 0; g < NRAM; g++) begin : g_line
            line_ram #(
                .DATA_W (DATA_W),
                .DEPTH  (LINE_W),
                .A_W    (X_W)
            ) u_line (
                .clk   (clk),
                .en    (accept),
                .we    (accept && (sel_p0 == S_W'(g))),
                .addr  (x_p0),
                .wdata (bus.in_data),
                .rdata (rd_data[g])
            );
        end
    endgenerate

    // Position counters and ring pointer for the next pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt   <= '0;
            y_cnt   <= '0;
            sel_cnt <= '0;
        end else if (accept) begin
            if (x_p0 == X_W'(LINE_W - 1)) begin
                x_cnt   <= '0;
                y_cnt   <= sat_inc_y(y_p0);
                sel_cnt <= ring_inc(sel_p0);
            end else begin
                x_cnt   <= x_p0 + X_W'(1);
                y_cnt   <= y_p0;
                sel_cnt <= sel_p0;
            end
        end
    end

    // Output register: load on accept, drop valid when consumed without refill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1    <= 1'b0;
            primed_p1 <= 1'b0;
            pix_p1    <= '0;
            x_p1      <= '0;
            y_p1      <= '0;
            win_p1    <= 1'b0;
            sel_p1    <= '0;
        end else if (accept) begin
            vld_p1    <= 1'b1;
            primed_p1 <= 1'b1;
            pix_p1    <= bus.in_data;
            x_p1      <= x_p0;
            y_p1      <= y_p0;
            win_p1    <= (y_p0 >= Y_W'(ROWS - 1));
            sel_p1    <= sel_p0;
        end else if (bus.out_ready) begin
            vld_p1    <= 1'b0;
        end
    end

    // Column assembly; RAM slices read as zero until the first pixel after reset.
    always_comb begin
        col             = '0;
        col[DATA_W-1:0] = pix_p1;
        for (int k = 1; k <= NRAM; k++) begin
            col[k*DATA_W +: DATA_W] = primed_p1 ? rd_data[ring_idx(sel_p1, k)] : '0;
        end
    end

    assign bus.out_valid  = vld_p1;
    assign bus.out_col    = col;
    assign bus.out_x      = x_p1;
    assign bus.out_y      = y_p1;
    assign bus.out_win_ok = win_p1;

endmodule

// File: tb/tb_line_window_buffer.sv
// Directed bench for line_window_buffer: a small 8-bit/4-pixel/3-row
// instance for fill, backpressure, wrap, resync and reset, plus a
// 32-bit/76-pixel/5-row instance for the deep-window case.
module tb_line_window_buffer;
    import edge_pkg::*;

    localparam int DW  = 8;
    localparam int LW  = 4;
    localparam int RW  = 3;
    localparam int YW  = 16;
    localparam int BDW = 32;
    localparam int BLW = 76;
    localparam int BRW = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    line_window_buffer_if #(.DATA_W(DW),  .LINE_W(LW),  .ROWS(RW),  .Y_W(YW)) sif ();
    line_window_buffer_if #(.DATA_W(BDW), .LINE_W(BLW), .ROWS(BRW), .Y_W(YW)) bif ();

    line_window_buffer #(.DATA_W(DW), .LINE_W(LW), .ROWS(RW), .Y_W(YW)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif.slave)
    );

    line_window_buffer #(.DATA_W(BDW), .LINE_W(BLW), .ROWS(BRW), .Y_W(YW)) u_big (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.slave)
    );

    typedef struct {
        logic        sof;
        logic [7:0]  data;
        logic [23:0] col;
        logic [23:0] mask;
        int          x;
        int          y;
        logic        win;
    } vec_t;

    vec_t fill_tab [12];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_s(input logic sof, input logic [7:0] d);
        @(negedge clk);
        sif.in_valid = 1'b1;
        sif.in_sof   = sof;
        sif.in_data  = d;
        @(posedge clk);
        #1;
        sif.in_valid = 1'b0;
        sif.in_sof   = 1'b0;
    endtask

    task automatic push_b(input logic sof, input logic [31:0] d);
        @(negedge clk);
        bif.in_valid = 1'b1;
        bif.in_sof   = sof;
        bif.in_data  = d;
        @(posedge clk);
        #1;
        bif.in_valid = 1'b0;
        bif.in_sof   = 1'b0;
    endtask

    task automatic chk_out(input string tag, input int x, input int y, input logic win);
        chk({tag, " valid"}, 64'(sif.out_valid), 64'(1));
        chk({tag, " x"},     64'(sif.out_x),     64'(x));
        chk({tag, " y"},     64'(sif.out_y),     64'(y));
        chk({tag, " win"},   64'(sif.out_win_ok), 64'(win));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] base;

        // Fill vectors: pixel i of a 4-wide frame sits at (i%4, i/4).
        for (int i = 0; i < 12; i++) begin
            fill_tab[i].sof  = (i == 0);
            fill_tab[i].data = 8'(i);
            fill_tab[i].x    = i % 4;
            fill_tab[i].y    = i / 4;
            fill_tab[i].win  = (i >= 8);
            fill_tab[i].col  = {(i >= 8) ? 8'(i - 8) : 8'h00,
                                (i >= 4) ? 8'(i - 4) : 8'h00,
                                8'(i)};
            fill_tab[i].mask = (i >= 8) ? 24'hFFFFFF : (i >= 4) ? 24'h00FFFF : 24'h0000FF;
        end

        sif.in_valid = 1'b0; sif.in_sof = 1'b0; sif.in_data = '0; sif.out_ready = 1'b1;
        bif.in_valid = 1'b0; bif.in_sof = 1'b0; bif.in_data = '0; bif.out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset valid", 64'(sif.out_valid),  64'(0));
        chk("reset ready", 64'(sif.in_ready),   64'(1));
        chk("reset col",   64'(sif.out_col),    64'(0));
        chk("reset x",     64'(sif.out_x),      64'(0));
        chk("reset y",     64'(sif.out_y),      64'(0));
        chk("reset win",   64'(sif.out_win_ok), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Fill and wrap over three lines
        for (int i = 0; i < 12; i++) begin
            push_s(fill_tab[i].sof, fill_tab[i].data);
            chk_out($sformatf("fill%0d", i), fill_tab[i].x, fill_tab[i].y, fill_tab[i].win);
            chk($sformatf("fill%0d col", i), 64'(sif.out_col & fill_tab[i].mask),
                64'(fill_tab[i].col & fill_tab[i].mask));
        end
        @(posedge clk);
        #1;
        chk("drain valid", 64'(sif.out_valid), 64'(0));
        chk("drain ready", 64'(sif.in_ready),  64'(1));

        // Backpressure after pixel 5 of a new frame
        for (int i = 0; i < 6; i++) begin
            push_s(i == 0, 8'(i));
        end
        sif.out_ready = 1'b0;
        #1;
        chk("bp ready low", 64'(sif.in_ready), 64'(0));
        sif.in_valid = 1'b1;
        sif.in_data  = 8'h06;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            chk("bp hold valid", 64'(sif.out_valid),   64'(1));
            chk("bp hold pix",   64'(sif.out_col[7:0]), 64'(5));
            chk("bp hold x",     64'(sif.out_x),       64'(1));
            chk("bp hold y",     64'(sif.out_y),       64'(1));
            chk("bp hold ready", 64'(sif.in_ready),    64'(0));
        end
        @(negedge clk);
        sif.out_ready = 1'b1;
        @(posedge clk);
        #1;
        sif.in_valid = 1'b0;
        chk_out("bp px6", 2, 1, 1'b0);
        chk("bp px6 col", 64'(sif.out_col[15:0]), 64'(16'h0206));
        push_s(1'b0, 8'h07);
        chk_out("bp px7", 3, 1, 1'b0);
        push_s(1'b0, 8'h08);
        chk_out("bp px8", 0, 2, 1'b1);
        chk("bp px8 col", 64'(sif.out_col), 64'(24'h000408));

        // Mid-line resync: sof on the third pixel of line 2
        push_s(1'b0, 8'h09);
        chk_out("rs px9", 1, 2, 1'b1);
        push_s(1'b1, 8'h0A);
        chk_out("rs sof", 0, 0, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            push_s(1'b0, 8'(8'h40 + i));
            chk_out($sformatf("rs%0d", i), i % 4, i / 4, (i >= 8));
        end
        chk("rs col", 64'(sif.out_col), 64'(24'h0A4448));

        // Asynchronous reset between clock edges, mid-line
        push_s(1'b0, 8'h55);
        chk_out("ar px", 1, 2, 1'b1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar valid", 64'(sif.out_valid),  64'(0));
        chk("ar col",   64'(sif.out_col),    64'(0));
        chk("ar x",     64'(sif.out_x),      64'(0));
        chk("ar y",     64'(sif.out_y),      64'(0));
        chk("ar win",   64'(sif.out_win_ok), 64'(0));
        chk("ar ready", 64'(sif.in_ready),   64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        push_s(1'b0, 8'h77);
        chk_out("ar first", 0, 0, 1'b0);
        chk("ar first pix", 64'(sif.out_col[7:0]), 64'(8'h77));

        // Deep window: 32-bit, 76 pixels, 5 rows
        base = 32'hA000_0000;
        for (int i = 0; i <= 304; i++) begin
            push_b(i == 0, base + 32'(i));
            if (i == 75) begin
                chk("big x75", 64'(bif.out_x), 64'(75));
                chk("big y75", 64'(bif.out_y), 64'(0));
            end
            if (i == 76) begin
                chk("big x76", 64'(bif.out_x), 64'(0));
                chk("big y76", 64'(bif.out_y), 64'(1));
            end
            if (i == 303) begin
                chk("big win303", 64'(bif.out_win_ok), 64'(0));
            end
        end
        chk("big win304", 64'(bif.out_win_ok), 64'(1));
        chk("big valid",  64'(bif.out_valid),  64'(1));
        chk("big x",      64'(bif.out_x),      64'(0));
        chk("big y",      64'(bif.out_y),      64'(4));
        for (int k = 0; k < BRW; k++) begin
            chk($sformatf("big slice%0d", k), 64'(bif.out_col[k*BDW +: BDW]),
                64'(base + 32'(304 - 76 * k)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
